// File: rtl/sha2_message_pad.sv
`default_nettype none
// ============================================================================
// Module   : sha2_message_pad
// Purpose  : SHA-2 message padder: masks message tail, appends '1', zeros and
//            big-endian bit length; one block per cycle through a single
//            output register.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module sha2_message_pad #(
    parameter int BLOCK_W = 512,
    parameter int LEN_W   = 64
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               sync_rst,
    input  logic [LEN_W-1:0]   cfg_size,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic               data_in_last,
    input  logic               data_in_valid,
    output logic               data_in_ready,
    output logic [BLOCK_W-1:0] data_out,
    output logic               data_out_last,
    output logic               data_out_valid,
    input  logic               data_out_ready,
    output logic               err_frame
);
    localparam int                  c_log_bw  = $clog2(BLOCK_W);
    localparam int                  c_cnt_w   = LEN_W - c_log_bw;
    localparam logic [c_log_bw-1:0] c_fit_max = c_log_bw'(BLOCK_W - LEN_W - 1);
    localparam logic [BLOCK_W-1:0]  c_ones    = '1;
    localparam logic [BLOCK_W-1:0]  c_top     = {1'b1, {(BLOCK_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_EXTRA = 2'd2
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_size;
    logic [c_cnt_w-1:0] r_k;
    logic               r_mode_one;
    logic [BLOCK_W-1:0] r_out;
    logic               r_out_last;
    logic               r_out_valid;
    logic               r_err;

    logic [c_log_bw-1:0] w_r;
    logic [c_cnt_w:0]    w_n;
    logic [c_cnt_w:0]    w_idx;
    logic                w_is_last;
    logic                w_fits;
    logic                w_out_free;
    logic                w_in_fire;
    logic [BLOCK_W-1:0]  w_len;
    logic [BLOCK_W-1:0]  w_keep;
    logic [BLOCK_W-1:0]  w_one;
    logic [BLOCK_W-1:0]  w_last_blk;
    logic [BLOCK_W-1:0]  w_extra;

    assign w_r       = r_size[c_log_bw-1:0];
    assign w_n       = {1'b0, r_size[LEN_W-1:c_log_bw]} + {{c_cnt_w{1'b0}}, |w_r};
    // 1-based index of the block currently offered on data_in
    assign w_idx     = {1'b0, r_k} + {{c_cnt_w{1'b0}}, 1'b1};
    assign w_is_last = (w_idx == w_n);
    assign w_fits    = (w_r <= c_fit_max);
    assign w_len     = {{(BLOCK_W-LEN_W){1'b0}}, r_size};
    assign w_keep    = ~(c_ones >> w_r);
    assign w_one     = c_top >> w_r;
    assign w_extra   = r_mode_one ? (c_top | w_len) : w_len;

    assign w_out_free = !r_out_valid || data_out_ready;
    assign w_in_fire  = data_in_valid && data_in_ready;

    always_comb begin
        w_last_blk = data_in;
        if (w_r != '0) begin
            w_last_blk = (data_in & w_keep) | w_one;
            if (w_fits) begin
                w_last_blk = w_last_blk | w_len;
            end
        end
    end

    assign cfg_ready      = (r_state == S_IDLE);
    assign data_in_ready  = (r_state == S_DATA) && w_out_free;
    assign data_out       = r_out;
    assign data_out_last  = r_out_last;
    assign data_out_valid = r_out_valid;
    assign err_frame      = r_err;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_size      <= '0;
            r_k         <= '0;
            r_mode_one  <= 1'b1;
            r_out       <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else if (sync_rst) begin
            r_state     <= S_IDLE;
            r_size      <= '0;
            r_k         <= '0;
            r_mode_one  <= 1'b1;
            r_out       <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_out_valid && data_out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        r_size     <= cfg_size;
                        r_k        <= '0;
                        r_mode_one <= 1'b1;
                        r_state    <= (cfg_size == '0) ? S_EXTRA : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_in_fire) begin
                        r_k         <= w_idx[c_cnt_w-1:0];
                        r_out_valid <= 1'b1;
                        r_err       <= (data_in_last != w_is_last);
                        if (!w_is_last) begin
                            r_out      <= data_in;
                            r_out_last <= 1'b0;
                        end else begin
                            r_out      <= w_last_blk;
                            r_out_last <= (w_r != '0) && w_fits;
                            // Block-aligned end needs the '1' in a fresh block;
                            // an overflowing tail needs only the length block.
                            if (w_r == '0) begin
                                r_mode_one <= 1'b1;
                                r_state    <= S_EXTRA;
                            end else if (w_fits) begin
                                r_state    <= S_IDLE;
                            end else begin
                                r_mode_one <= 1'b0;
                                r_state    <= S_EXTRA;
                            end
                        end
                    end
                end
                S_EXTRA: begin
                    if (w_out_free) begin
                        r_out       <= w_extra;
                        r_out_last  <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sha2_message_pad.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha2_message_pad
// Purpose  : Directed self-checking bench for sha2_message_pad (512 and 1024).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha2_message_pad;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         nrst, sync_rst;
    logic [63:0]  cfg_size;
    logic         cfg_valid, cfg_ready;
    logic [511:0] data_in;
    logic         data_in_last, data_in_valid, data_in_ready;
    logic [511:0] data_out;
    logic         data_out_last, data_out_valid, data_out_ready, err_frame;

    logic [127:0]  wcfg_size;
    logic          wcfg_valid, wcfg_ready;
    logic [1023:0] wdata_in;
    logic          wdata_in_last, wdata_in_valid, wdata_in_ready;
    logic [1023:0] wdata_out;
    logic          wdata_out_last, wdata_out_valid, wdata_out_ready, werr_frame;

    sha2_message_pad #(.BLOCK_W(512), .LEN_W(64)) dut (
        .clk(clk), .nrst(nrst), .sync_rst(sync_rst),
        .cfg_size(cfg_size), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .data_in(data_in), .data_in_last(data_in_last),
        .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .data_out(data_out), .data_out_last(data_out_last),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .err_frame(err_frame)
    );

    sha2_message_pad #(.BLOCK_W(1024), .LEN_W(128)) dut_w (
        .clk(clk), .nrst(nrst), .sync_rst(sync_rst),
        .cfg_size(wcfg_size), .cfg_valid(wcfg_valid), .cfg_ready(wcfg_ready),
        .data_in(wdata_in), .data_in_last(wdata_in_last),
        .data_in_valid(wdata_in_valid), .data_in_ready(wdata_in_ready),
        .data_out(wdata_out), .data_out_last(wdata_out_last),
        .data_out_valid(wdata_out_valid), .data_out_ready(wdata_out_ready),
        .err_frame(werr_frame)
    );

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        for (int i = 0; i < 2; i++)
            chk($sformatf("%s[%0d]", tag, i), got[i*256 +: 256], exp[i*256 +: 256]);
    endtask

    task automatic chk_wblk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s[%0d]", tag, i), got[i*256 +: 256], exp[i*256 +: 256]);
    endtask

    // Output collection, error pulse counting and stall-stability checks
    logic [511:0]  oq_d[$];
    logic          oq_l[$];
    logic [1023:0] wq_d[$];
    logic          wq_l[$];
    int            err_pulses = 0;
    bit            bp_on = 1'b0;
    logic          stalled = 1'b0;
    logic [513:0]  held;

    always @(negedge clk) begin
        if (data_out_valid && data_out_ready) begin
            oq_d.push_back(data_out);
            oq_l.push_back(data_out_last);
        end
        if (wdata_out_valid && wdata_out_ready) begin
            wq_d.push_back(wdata_out);
            wq_l.push_back(wdata_out_last);
        end
        if (err_frame) err_pulses++;
        if (bp_on && stalled) begin
            chk("stall_d0", data_out[255:0], held[255:0]);
            chk("stall_d1", data_out[511:256], held[511:256]);
            chk("stall_ctl", {data_out_valid, data_out_last}, held[513:512]);
        end
        stalled = bp_on && data_out_valid && !data_out_ready;
        held    = {data_out_valid, data_out_last, data_out};
    end

    always @(posedge clk) begin
        #1;
        if (bp_on) data_out_ready = ($urandom_range(0, 2) != 0);
    end

    task automatic send_cfg(input logic [63:0] sz);
        cfg_size  = sz;
        cfg_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cfg_ready) begin
                @(posedge clk); #1;
                cfg_valid = 1'b0;
                return;
            end
        end
        chk("cfg_timeout", cfg_ready, 1);
        cfg_valid = 1'b0;
    endtask

    task automatic send_blk(input logic [511:0] d, input logic last);
        data_in       = d;
        data_in_last  = last;
        data_in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (data_in_ready) begin
                @(posedge clk); #1;
                data_in_valid = 1'b0;
                return;
            end
        end
        chk("blk_timeout", data_in_ready, 1);
        data_in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        for (int i = 0; i < 2000; i++) begin
            if (oq_d.size() >= n) return;
            @(negedge clk);
        end
        chk("out_timeout", oq_d.size(), n);
    endtask

    task automatic clear_q();
        oq_d.delete();
        oq_l.delete();
    endtask

    logic [511:0]  d24, dpat, e24, e448a, e448b, e447, e512b, e0, e1024c;
    logic [1023:0] dpw, ew1, ew2;
    logic [511:0]  bp_exp[5];
    logic          bp_last[5];

    initial begin
        nrst = 1'b0; sync_rst = 1'b0;
        cfg_size = '0; cfg_valid = 1'b0;
        data_in = '0; data_in_last = 1'b0; data_in_valid = 1'b0; data_out_ready = 1'b1;
        wcfg_size = '0; wcfg_valid = 1'b0;
        wdata_in = '0; wdata_in_last = 1'b0; wdata_in_valid = 1'b0; wdata_out_ready = 1'b1;

        d24 = {24'h616263, {488{1'b1}}};
        for (int i = 0; i < 16; i++) dpat[i*32 +: 32] = 32'h01234567 + i * 32'h11111111;
        for (int i = 0; i < 32; i++) dpw[i*32 +: 32] = 32'hC0DE0000 + i;
        e24 = '0; e24[511:480] = 32'h61626380; e24[63:0] = 64'd24;
        e448a  = {dpat[511:64], 64'h8000_0000_0000_0000};
        e448b  = {448'b0, 64'h1C0};
        e447   = {dpat[511:65], 1'b1, 64'd447};
        e512b  = {1'b1, 447'b0, 64'h200};
        e0     = {1'b1, 511'b0};
        e1024c = {1'b1, 447'b0, 64'h400};
        ew1    = {dpw[1023:24], 1'b1, 23'b0};
        ew2    = {896'b0, 128'd1000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", data_out_valid, 0);
        chk("rst_last", data_out_last, 0);
        chk_blk("rst_data", data_out, '0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_in_ready", data_in_ready, 0);
        chk("rst_err", err_frame, 0);
        chk("rst_wvalid", wdata_out_valid, 0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;

        // abc, fill bits masked, fits in one block
        clear_q();
        send_cfg(64'd24);
        send_blk(d24, 1'b1);
        wait_outs(1);
        repeat (3) @(posedge clk); #1;
        chk("t24_n", oq_d.size(), 1);
        chk_blk("t24_d", oq_d[0], e24);
        chk("t24_last", oq_l[0], 1);

        // 448 bits: overflow into a length-only block
        clear_q();
        send_cfg(64'd448);
        send_blk(dpat, 1'b1);
        wait_outs(2);
        @(posedge clk); #1;
        chk_blk("t448_d0", oq_d[0], e448a);
        chk("t448_l0", oq_l[0], 0);
        chk_blk("t448_d1", oq_d[1], e448b);
        chk("t448_l1", oq_l[1], 1);

        // 447 bits: largest tail that still fits
        clear_q();
        send_cfg(64'd447);
        send_blk(dpat, 1'b1);
        wait_outs(1);
        repeat (3) @(posedge clk); #1;
        chk("t447_n", oq_d.size(), 1);
        chk_blk("t447_d", oq_d[0], e447);
        chk("t447_last", oq_l[0], 1);

        // 512 bits: block-aligned
        clear_q();
        send_cfg(64'd512);
        send_blk(dpat, 1'b1);
        wait_outs(2);
        @(posedge clk); #1;
        chk_blk("t512_d0", oq_d[0], dpat);
        chk("t512_l0", oq_l[0], 0);
        chk_blk("t512_d1", oq_d[1], e512b);
        chk("t512_l1", oq_l[1], 1);

        // zero-length message
        clear_q();
        send_cfg(64'd0);
        wait_outs(1);
        repeat (3) @(posedge clk); #1;
        chk("t0_n", oq_d.size(), 1);
        chk_blk("t0_d", oq_d[0], e0);
        chk("t0_last", oq_l[0], 1);
        chk("no_err_so_far", err_pulses, 0);

        // early data_in_last on block 1 of 2
        clear_q();
        err_pulses = 0;
        send_cfg(64'd1024);
        send_blk(dpat, 1'b1);
        send_blk(~dpat, 1'b1);
        wait_outs(3);
        repeat (3) @(posedge clk); #1;
        chk("terr_pulses", err_pulses, 1);
        chk_blk("terr_d0", oq_d[0], dpat);
        chk("terr_l0", oq_l[0], 0);
        chk_blk("terr_d1", oq_d[1], ~dpat);
        chk("terr_l1", oq_l[1], 0);
        chk_blk("terr_d2", oq_d[2], e1024c);
        chk("terr_l2", oq_l[2], 1);

        // three back-to-back messages under random backpressure
        bp_exp[0] = e24;   bp_last[0] = 1'b1;
        bp_exp[1] = e448a; bp_last[1] = 1'b0;
        bp_exp[2] = e448b; bp_last[2] = 1'b1;
        bp_exp[3] = dpat;  bp_last[3] = 1'b0;
        bp_exp[4] = e512b; bp_last[4] = 1'b1;
        clear_q();
        bp_on = 1'b1;
        send_cfg(64'd24);  send_blk(d24, 1'b1);
        send_cfg(64'd448); send_blk(dpat, 1'b1);
        send_cfg(64'd512); send_blk(dpat, 1'b1);
        wait_outs(5);
        bp_on = 1'b0;
        @(posedge clk); #1;
        data_out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("tbp_n", oq_d.size(), 5);
        for (int i = 0; i < 5 && i < oq_d.size(); i++) begin
            chk_blk($sformatf("tbp_d%0d", i), oq_d[i], bp_exp[i]);
            chk($sformatf("tbp_l%0d", i), oq_l[i], bp_last[i]);
        end

        // nrst while stalled in EXTRA
        clear_q();
        data_out_ready = 1'b0;
        send_cfg(64'd512);
        send_blk(dpat, 1'b1);
        repeat (2) @(posedge clk); #1;
        nrst = 1'b0;
        #1;
        chk("arst_valid", data_out_valid, 0);
        chk("arst_last", data_out_last, 0);
        chk_blk("arst_data", data_out, '0);
        chk("arst_cfg_ready", cfg_ready, 1);
        chk("arst_in_ready", data_in_ready, 0);
        chk("arst_err", err_frame, 0);
        @(posedge clk); #1;
        nrst = 1'b1;
        data_out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("arst_no_out", oq_d.size(), 0);
        send_cfg(64'd24);
        send_blk(d24, 1'b1);
        wait_outs(1);
        chk_blk("arst_next_d", oq_d[0], e24);
        chk("arst_next_l", oq_l[0], 1);

        // sync_rst mid-message
        @(posedge clk); #1;
        clear_q();
        data_out_ready = 1'b0;
        send_cfg(64'd1024);
        send_blk(dpat, 1'b0);
        sync_rst = 1'b1;
        @(posedge clk); #1;
        sync_rst = 1'b0;
        chk("srst_valid", data_out_valid, 0);
        chk("srst_cfg_ready", cfg_ready, 1);
        chk("srst_in_ready", data_in_ready, 0);
        data_out_ready = 1'b1;
        send_cfg(64'd448);
        send_blk(dpat, 1'b1);
        wait_outs(2);
        chk_blk("srst_next_d0", oq_d[0], e448a);
        chk_blk("srst_next_d1", oq_d[1], e448b);
        chk("srst_next_l1", oq_l[1], 1);

        // 1024/128 instance, 1000-bit message
        @(posedge clk); #1;
        wcfg_size = 128'd1000;
        wcfg_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wcfg_ready) break;
        end
        @(posedge clk); #1;
        wcfg_valid = 1'b0;
        wdata_in = dpw; wdata_in_last = 1'b1; wdata_in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wdata_in_ready) break;
        end
        @(posedge clk); #1;
        wdata_in_valid = 1'b0;
        for (int i = 0; i < 50 && wq_d.size() < 2; i++) @(negedge clk);
        repeat (3) @(posedge clk); #1;
        chk("tw_n", wq_d.size(), 2);
        if (wq_d.size() >= 2) begin
            chk_wblk("tw_d0", wq_d[0], ew1);
            chk("tw_l0", wq_l[0], 0);
            chk_wblk("tw_d1", wq_d[1], ew2);
            chk("tw_l1", wq_l[1], 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
